// File: rtl/blink_share_scheduler_if.sv
// Bundle of the request, pattern-field and LED/status signals shared by one
// blink scheduler and the requesters that use it.
interface blink_share_scheduler_if #(
    parameter int NREQ = 4,
    parameter int TW   = 4
);
    logic [NREQ-1:0]    req;
    logic [TW*NREQ-1:0] on_len;
    logic [TW*NREQ-1:0] off_len;
    logic [3*NREQ-1:0]  reps;
    logic               light;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic               busy;

    modport master (
        output req, on_len, off_len, reps,
        input  light, grant, done, busy
    );

    modport slave (
        input  req, on_len, off_len, reps,
        output light, grant, done, busy
    );
endinterface

// File: rtl/blink_share_scheduler.sv
// Round-robin scheduler that lends one LED and one duration timer to NREQ
// requesters, each playing a latched ON/OFF blink pattern repeated reps times.
//
// state | meaning
// IDLE  | no owner; round-robin pick of the next requester
// ON    | light driven high for the latched on duration
// OFF   | light low for the latched off duration; repeat or finish
module blink_share_scheduler #(
    parameter int NREQ = 4,
    parameter int TW   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    blink_share_scheduler_if.slave   bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    state_t            r_state;
    logic [TW-1:0]     r_timer;
    logic [2:0]        r_reps_left;
    logic [TW-1:0]     r_on_last;
    logic [TW-1:0]     r_off_last;
    logic [IW-1:0]     r_rr_ptr;
    logic [NREQ-1:0]   r_grant;
    logic [NREQ-1:0]   r_done;

    state_t            w_state_nxt;
    logic [TW-1:0]     w_timer_nxt;
    logic [2:0]        w_reps_nxt;
    logic [TW-1:0]     w_on_nxt;
    logic [TW-1:0]     w_off_nxt;
    logic [IW-1:0]     w_ptr_nxt;
    logic [NREQ-1:0]   w_grant_nxt;
    logic [NREQ-1:0]   w_done_nxt;

    logic              w_found;
    logic [IW-1:0]     w_win;
    logic [IW-1:0]     w_idx;
    logic [TW-1:0]     w_sel_on;
    logic [TW-1:0]     w_sel_off;
    logic [2:0]        w_sel_reps;
    logic              w_owner_req;

    // Search begins one past the last winner so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = IW'((int'(r_rr_ptr) + k) % NREQ);
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_sel_on   = '0;
        w_sel_off  = '0;
        w_sel_reps = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == IW'(i)) begin
                w_sel_on   = bus.on_len[TW*i +: TW];
                w_sel_off  = bus.off_len[TW*i +: TW];
                w_sel_reps = bus.reps[3*i +: 3];
            end
        end
    end

    assign w_owner_req = bus.req[r_rr_ptr];

    // Durations are kept as terminal count (length - 1); zero lengths act as one.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_reps_nxt  = r_reps_left;
        w_on_nxt    = r_on_last;
        w_off_nxt   = r_off_last;
        w_ptr_nxt   = r_rr_ptr;
        w_grant_nxt = r_grant;
        w_done_nxt  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_ON;
                    w_timer_nxt = '0;
                    w_on_nxt    = (w_sel_on == '0) ? '0 : w_sel_on - TW'(1);
                    w_off_nxt   = (w_sel_off == '0) ? '0 : w_sel_off - TW'(1);
                    w_reps_nxt  = (w_sel_reps == 3'd0) ? 3'd1 : w_sel_reps;
                    w_ptr_nxt   = w_win;
                    w_grant_nxt = NREQ'(1) << w_win;
                end
            end
            S_ON: begin
                if (!w_owner_req) begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
                    w_grant_nxt = '0;
                end else if (r_timer == r_on_last) begin
                    w_state_nxt = S_OFF;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            S_OFF: begin
                if (!w_owner_req) begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
                    w_grant_nxt = '0;
                end else if (r_timer == r_off_last) begin
                    w_timer_nxt = '0;
                    if (r_reps_left > 3'd1) begin
                        w_reps_nxt  = r_reps_left - 3'd1;
                        w_state_nxt = S_ON;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_grant_nxt = '0;
                        w_done_nxt  = r_grant;
                    end
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_timer_nxt = '0;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_reps_left <= '0;
            r_on_last   <= '0;
            r_off_last  <= '0;
            r_rr_ptr    <= IW'(NREQ - 1);
            r_grant     <= '0;
            r_done      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_reps_left <= w_reps_nxt;
            r_on_last   <= w_on_nxt;
            r_off_last  <= w_off_nxt;
            r_rr_ptr    <= w_ptr_nxt;
            r_grant     <= w_grant_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign bus.light = (r_state == S_ON);
    assign bus.busy  = (r_state != S_IDLE);
    assign bus.grant = r_grant;
    assign bus.done  = r_done;

endmodule

// File: tb/tb_blink_share_scheduler.sv
// Scoreboard bench: stimulus pushes whole expected blink patterns built from
// the pattern rules; a monitor rebuilds each observed pattern and compares.
module tb_blink_share_scheduler;
    localparam int NREQ = 4;
    localparam int TW   = 4;
    localparam int FW   = TW * NREQ;
    localparam int RW   = 3 * NREQ;
    localparam int MAXL = 256;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    blink_share_scheduler_if #(.NREQ(NREQ), .TW(TW)) bif ();

    blink_share_scheduler #(.NREQ(NREQ), .TW(TW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    typedef struct {
        int idx;
        int len;
        bit seq [MAXL];
        bit done_exp;
        int gap;
    } rec_t;

    rec_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   gap_hint = -1;
    int   m_rr = NREQ - 1;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int pat_len(input int on, input int off, input int rp);
        return eff(rp) * (eff(on) + eff(off));
    endfunction

    function automatic rec_t build(input int idx, input int on, input int off, input int rp,
                                   input int cut, input bit dn, input int gap);
        rec_t r;
        int pos = 0;
        r.idx = idx;
        r.len = cut;
        r.done_exp = dn;
        r.gap = gap;
        for (int i = 0; i < MAXL; i++) r.seq[i] = 1'b0;
        for (int k = 0; k < eff(rp); k++) begin
            for (int j = 0; j < eff(on); j++) begin
                if (pos < MAXL) r.seq[pos] = 1'b1;
                pos++;
            end
            pos += eff(off);
        end
        return r;
    endfunction

    task automatic set_slot(input int i, input int on, input int off, input int rp);
        bif.on_len[TW*i +: TW] = TW'(on);
        bif.off_len[TW*i +: TW] = TW'(off);
        bif.reps[3*i +: 3] = 3'(rp);
    endtask

    task automatic rand_fields();
        bif.on_len  = FW'($urandom);
        bif.off_len = FW'($urandom);
        bif.reps    = RW'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
        if (gap_hint >= 0) gap_hint += n;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_light"}, int'(bif.light), 0);
        chk({tag, "_grant"}, int'(bif.grant), 0);
        chk({tag, "_done"},  int'(bif.done), 0);
        chk({tag, "_busy"},  int'(bif.busy), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bif.req = '0;
        @(negedge clk);
        #1;
        reset = 1'b0;
        m_rr = NREQ - 1;
        gap_hint = -1;
    endtask

    // Called one cycle before the expected grant edge, with the block idle.
    task automatic run_pattern(input int idx, input int on, input int off, input int rp,
                               input int abort_at, input bit noise, input int reset_at,
                               input int new_on);
        int L;
        int stop;
        logic [NREQ-1:0] own;
        if (noise) rand_fields();
        set_slot(idx, on, off, rp);
        own = NREQ'(1) << idx;
        bif.req = own;
        L = pat_len(on, off, rp);
        stop = (abort_at >= 0) ? abort_at : reset_at;
        exp_q.push_back(build(idx, on, off, rp, (stop >= 0) ? stop + 1 : L, stop < 0, gap_hint));
        m_rr = idx;
        for (int c = 0; c <= MAXL + 2; c++) begin
            @(negedge clk);
            #1;
            if (reset_at == c) begin
                reset = 1'b1;
                bif.req = '0;
                #1;
                check_all_zero("reset_mid");
                repeat (2) @(negedge clk);
                #1;
                reset = 1'b0;
                m_rr = NREQ - 1;
                gap_hint = -1;
                return;
            end else if (abort_at == c) begin
                bif.req = '0;
            end else if (abort_at >= 0 && c == abort_at + 1) begin
                check_all_zero("after_abort");
                gap_hint = 1;
                return;
            end else if (abort_at < 0 && c == L) begin
                bif.req = '0;
                gap_hint = 1;
                return;
            end else begin
                if (new_on >= 0 && c == 1) bif.on_len[TW*idx +: TW] = TW'(new_on);
                if (noise) begin
                    rand_fields();
                    bif.req = NREQ'($urandom) | own;
                end
            end
        end
    endtask

    // Hold a request mask for n consecutive patterns.
    task automatic run_held(input logic [NREQ-1:0] mask, input int n, input bit rnd);
        int on_a[NREQ];
        int off_a[NREQ];
        int rp_a[NREQ];
        int w;
        int L;
        for (int i = 0; i < NREQ; i++) begin
            on_a[i]  = rnd ? int'($urandom_range(0, 5)) : 1;
            off_a[i] = rnd ? int'($urandom_range(0, 5)) : 1;
            rp_a[i]  = rnd ? int'($urandom_range(0, 3)) : 1;
            set_slot(i, on_a[i], off_a[i], rp_a[i]);
        end
        bif.req = mask;
        for (int p = 0; p < n; p++) begin
            w = -1;
            for (int k = 1; k <= NREQ; k++) begin
                if (w < 0 && mask[(m_rr + k) % NREQ]) w = (m_rr + k) % NREQ;
            end
            L = pat_len(on_a[w], off_a[w], rp_a[w]);
            exp_q.push_back(build(w, on_a[w], off_a[w], rp_a[w], L, 1'b1, (p == 0) ? gap_hint : 1));
            m_rr = w;
            repeat (L + 1) @(negedge clk);
            #1;
        end
        bif.req = '0;
        gap_hint = 1;
    endtask

    // Monitor: rebuilds each grant period into a light sequence and scores it.
    int              mon_in_pat = 0;
    int              mon_len = 0;
    int              mon_idle = 1000;
    int              mon_gap = 0;
    logic [NREQ-1:0] mon_grant = '0;
    bit              mon_seq [MAXL];

    always @(negedge clk) begin
        rec_t e;
        int   gidx;
        int   first;
        chk("busy_vs_grant", int'(bif.busy), int'(bif.grant != '0));
        chk("grant_onehot0", int'($onehot0(bif.grant)), 1);
        if (bif.grant == '0) chk("light_without_owner", int'(bif.light), 0);
        if (mon_in_pat == 0 && bif.grant != '0) begin
            chk("done_in_pattern", int'(bif.done), 0);
            mon_in_pat = 1;
            mon_grant = bif.grant;
            mon_gap = mon_idle;
            mon_seq[0] = bif.light;
            mon_len = 1;
        end else if (mon_in_pat != 0 && bif.grant != '0) begin
            chk("done_in_pattern", int'(bif.done), 0);
            chk("grant_stable", int'(bif.grant), int'(mon_grant));
            if (mon_len < MAXL) mon_seq[mon_len] = bif.light;
            mon_len++;
        end else if (mon_in_pat != 0) begin
            mon_in_pat = 0;
            mon_idle = 1;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pattern: got grant %b expected none", mon_grant);
            end else begin
                e = exp_q.pop_front();
                gidx = -1;
                for (int i = 0; i < NREQ; i++) if (mon_grant[i]) gidx = i;
                chk("grant_index", gidx, e.idx);
                chk("pattern_length", mon_len, e.len);
                first = -1;
                for (int i = 0; i < MAXL; i++) begin
                    if (first < 0 && i < mon_len && i < e.len && mon_seq[i] != e.seq[i]) first = i;
                end
                chk("light_seq_first_diff", first, -1);
                chk("done_pulse", int'(bif.done), e.done_exp ? (1 << e.idx) : 0);
                if (e.gap >= 0) chk("idle_gap", mon_gap, e.gap);
            end
        end else begin
            mon_idle++;
            chk("done_quiet", int'(bif.done), 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, on, off, rp, L, ab;
        reset = 1'b1;
        bif.req = '0;
        bif.on_len = '0;
        bif.off_len = '0;
        bif.reps = '0;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset_state");
        reset = 1'b0;
        idle(1);

        run_pattern(0, 3, 2, 2, -1, 1'b0, -1, -1);
        idle(1);

        do_reset();
        run_held(4'b1111, 5, 1'b0);

        run_pattern(2, 0, 0, 0, -1, 1'b0, -1, -1);
        run_pattern(1, 3, 2, 3, 6, 1'b0, -1, -1);

        run_pattern(0, 2, 3, 2, -1, 1'b0, -1, 9);
        run_pattern(0, 9, 1, 1, -1, 1'b0, -1, -1);

        run_pattern(3, 2, 4, 1, -1, 1'b0, 3, -1);
        idle(1);
        run_held(4'b1001, 2, 1'b0);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 5) == 0) begin
                run_held(NREQ'($urandom_range(1, (1 << NREQ) - 1)), int'($urandom_range(1, 4)), 1'b1);
            end else begin
                idx = int'($urandom_range(0, NREQ - 1));
                on  = int'($urandom_range(0, 6));
                off = int'($urandom_range(0, 6));
                rp  = int'($urandom_range(0, 7));
                L   = pat_len(on, off, rp);
                ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, L - 1)) : -1;
                run_pattern(idx, on, off, rp, ab, 1'($urandom_range(0, 1)), -1, -1);
            end
            idle(int'($urandom_range(0, 2)));
        end

        idle(4);
        chk("leftover_expected", exp_q.size(), 0);
        chk("open_pattern", mon_in_pat, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
